serial_pattern_gen: RTL and testbench

Serial bit-pattern transmitter, the driving end of the team's serial sequence detectors. It accepts a parallel pattern, a bit length and a repeat count through a start/ready handshake. It then shifts the pattern out MSB-first on a single-bit line, inserting forced-zero gap cycles between repetitions. It drives detector benches and in-system serial links.

---
 rtl/serial_pattern_gen_if.sv | 28 ++
 rtl/serial_pattern_gen.sv | 135 +++++++++++++
 tb/tb_serial_pattern_gen.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pattern_gen_if.sv
// Handshake and serial-output bundle for serial_pattern_gen.
// master = requester/consumer side, slave = the generator.
interface serial_pattern_gen_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [CNT_W-1:0] reps;
  logic             ready;
  logic             busy;
  logic             y_out;
  logic             y_valid;
  logic             done;

  modport master (
    output start, abort, pattern, len, reps,
    input  ready, busy, y_out, y_valid, done
  );

  modport slave (
    input  start, abort, pattern, len, reps,
    output ready, busy, y_out, y_valid, done
  );
endinterface

// File: rtl/serial_pattern_gen.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first,
// repeated reps times with GAP forced-zero cycles between repetitions.
module serial_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 1
) (
  input logic                 clk,
  input logic                 rst,
  serial_pattern_gen_if.slave bus
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic [IDX_W-1:0]   last_idx, last_nx;
  logic [CNT_W-1:0]   rep_cnt, rep_nx;
  logic [GAP_W-1:0]   gap_cnt, gap_nx;
  logic [WIDTH-1:0]   pat, pat_nx;
  logic [LEN_W-1:0]   eff_len;
  logic [LEN_W-1:0]   eff_m1;

  logic ready_nx, busy_nx, y_out_nx, y_valid_nx, done_nx;

  // Clamp the requested length to the physical pattern width.
  assign eff_len = (bus.len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : bus.len;
  assign eff_m1  = eff_len - LEN_W'(1);

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    last_nx  = last_idx;
    rep_nx   = rep_cnt;
    gap_nx   = gap_cnt;
    pat_nx   = pat;

    unique case (state)
      S_IDLE: begin
        if (!bus.abort && bus.start) begin
          pat_nx  = bus.pattern;
          last_nx = eff_m1[IDX_W-1:0];
          idx_nx  = eff_m1[IDX_W-1:0];
          rep_nx  = bus.reps;
          if (eff_len == '0 || bus.reps == '0) state_nx = S_DONE;
          else                                  state_nx = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bus.abort) begin
          state_nx = S_IDLE;
        end else if (idx == '0) begin
          // rep_cnt counts down to 1, never through 0, so all-ones reps is safe
          if (rep_cnt == CNT_W'(1)) begin
            state_nx = S_DONE;
          end else begin
            rep_nx = rep_cnt - CNT_W'(1);
            if (GAP == 0) begin
              idx_nx = last_idx;
            end else begin
              state_nx = S_GAP;
              gap_nx   = GAP_W'(GAP - 1);
            end
          end
        end else begin
          idx_nx = idx - IDX_W'(1);
        end
      end
      S_GAP: begin
        if (bus.abort) begin
          state_nx = S_IDLE;
        end else if (gap_cnt == '0) begin
          state_nx = S_SHIFT;
          idx_nx   = last_idx;
        end else begin
          gap_nx = gap_cnt - GAP_W'(1);
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    ready_nx   = (state_nx == S_IDLE);
    busy_nx    = (state_nx == S_SHIFT) || (state_nx == S_GAP);
    y_valid_nx = (state_nx == S_SHIFT);
    y_out_nx   = (state_nx == S_SHIFT) && pat_nx[idx_nx];
    done_nx    = (state_nx == S_DONE);
  end

  // Control and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      last_idx    <= '0;
      rep_cnt     <= '0;
      gap_cnt     <= '0;
      bus.ready   <= 1'b1;
      bus.busy    <= 1'b0;
      bus.y_out   <= 1'b0;
      bus.y_valid <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      last_idx    <= last_nx;
      rep_cnt     <= rep_nx;
      gap_cnt     <= gap_nx;
      bus.ready   <= ready_nx;
      bus.busy    <= busy_nx;
      bus.y_out   <= y_out_nx;
      bus.y_valid <= y_valid_nx;
      bus.done    <= done_nx;
    end
  end

  // Captured pattern is pure data and is only meaningful after an accept.
  always_ff @(posedge clk) begin
    pat <= pat_nx;
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Scoreboard bench for serial_pattern_gen: directed transfers push expected
// bit/done events; a negedge monitor pops and compares them as the DUT emits.
module tb_serial_pattern_gen;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    logic is_done;
    logic val;
    int   cyc;
  } ev_t;

  ev_t sb[$];
  ev_t e;

  serial_pattern_gen_if #(.WIDTH(8), .LEN_W(4), .CNT_W(4)) sif ();

  serial_pattern_gen #(.WIDTH(8), .LEN_W(4), .CNT_W(4), .GAP(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_bits(input int c0, input int first, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) sb.push_back('{1'b0, bits[n-1-i], c0 + first + i});
  endtask

  task automatic exp_done(input int c0, input int k);
    sb.push_back('{1'b1, 1'b0, c0 + k});
  endtask

  task automatic begin_xfer(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                            output int c0);
    @(negedge clk);
    sif.start   = 1'b1;
    sif.pattern = p;
    sif.len     = l;
    sif.reps    = r;
    c0 = cyc;
  endtask

  // Scramble inputs after the accept edge so capture is exercised.
  task automatic release_xfer();
    @(posedge clk);
    #1;
    sif.start   = 1'b0;
    sif.pattern = 8'h3C;
    sif.len     = 4'd7;
    sif.reps    = 4'd9;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sif.done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_ready_in_done"}, 32'(sif.ready), 32'd0);
    @(negedge clk);
    chk({name, "_ready_after"}, 32'(sif.ready), 32'd1);
    chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every valid bit or done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (sif.y_valid || sif.done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output cyc=%0d y_valid=%b y_out=%b done=%b required=none",
                   cyc, sif.y_valid, sif.y_out, sif.done);
        end else begin
          e = sb.pop_front();
          if ((e.is_done !== sif.done) || (e.is_done === sif.y_valid) ||
              (!e.is_done && (e.val !== sif.y_out)) || (e.cyc != cyc)) begin
            errors++;
            $display("FAIL event: got cyc=%0d valid=%b out=%b done=%b expected cyc=%0d done=%b out=%b",
                     cyc, sif.y_valid, sif.y_out, sif.done, e.cyc, e.is_done, e.val);
          end
        end
      end
      if (!sif.y_valid) begin
        checks++;
        if (sif.y_out !== 1'b0) begin
          errors++;
          $display("FAIL y_out_idle: got %b expected 0 at cyc=%0d", sif.y_out, cyc);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    clk = 1'b0;
    cyc = 0;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    sif.start = 1'b0;
    sif.abort = 1'b0;
    sif.pattern = '0;
    sif.len = '0;
    sif.reps = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(sif.ready), 32'd1);
    chk("rst_busy", 32'(sif.busy), 32'd0);
    chk("rst_y_out", 32'(sif.y_out), 32'd0);
    chk("rst_y_valid", 32'(sif.y_valid), 32'd0);
    chk("rst_done", 32'(sif.done), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 0x0F, len 4, reps 1: 1111 in cycles 1-4, done 5
    begin_xfer(8'h0F, 4'd4, 4'd1, c);
    exp_bits(c, 1, 16'b1111, 4);
    exp_done(c, 5);
    release_xfer();
    wait_done("t1");

    // 0x05, len 3, reps 3: 101 _ 101 _ 101, done 12
    begin_xfer(8'h05, 4'd3, 4'd3, c);
    exp_bits(c, 1, 16'b101, 3);
    exp_bits(c, 5, 16'b101, 3);
    exp_bits(c, 9, 16'b101, 3);
    exp_done(c, 12);
    release_xfer();
    wait_done("t2");

    // Zero length, then zero reps: done immediately, no bits
    begin_xfer(8'hFF, 4'd0, 4'd5, c);
    exp_done(c, 1);
    release_xfer();
    wait_done("t3_len0");
    begin_xfer(8'hFF, 4'd4, 4'd0, c);
    exp_done(c, 1);
    release_xfer();
    wait_done("t3_reps0");

    // len 12 clamps to 8 bits of 0xA5
    begin_xfer(8'hA5, 4'd12, 4'd1, c);
    exp_bits(c, 1, 16'b10100101, 8);
    exp_done(c, 9);
    release_xfer();
    wait_done("t4");

    // Max reps: single-bit pattern 15 times, bits on odd cycles, done 30
    begin_xfer(8'h01, 4'd1, 4'd15, c);
    for (int k = 0; k < 15; k++) exp_bits(c, 2 * k + 1, 16'b1, 1);
    exp_done(c, 30);
    release_xfer();
    wait_done("t5");

    // Abort in cycle 3 of 0xC3 x2; start while busy is ignored
    begin_xfer(8'hC3, 4'd8, 4'd2, c);
    exp_bits(c, 1, 16'b110, 3);
    release_xfer();
    @(negedge clk);
    @(negedge clk);
    sif.start = 1'b1;
    sif.pattern = 8'hFF;
    sif.len = 4'd1;
    sif.reps = 4'd1;
    @(negedge clk);
    sif.start = 1'b0;
    sif.abort = 1'b1;
    @(negedge clk);
    sif.abort = 1'b0;
    chk("abort_ready", 32'(sif.ready), 32'd1);
    chk("abort_busy", 32'(sif.busy), 32'd0);
    chk("abort_y_valid", 32'(sif.y_valid), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_sb_empty", 32'(sb.size()), 32'd0);

    begin_xfer(8'h02, 4'd2, 4'd1, c);
    exp_bits(c, 1, 16'b10, 2);
    exp_done(c, 3);
    release_xfer();
    wait_done("t6_after_abort");

    // abort and start together in IDLE: not accepted
    @(negedge clk);
    sif.start = 1'b1;
    sif.abort = 1'b1;
    sif.pattern = 8'hFF;
    sif.len = 4'd8;
    sif.reps = 4'd1;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    sif.abort = 1'b0;
    @(negedge clk);
    chk("abort_start_ready", 32'(sif.ready), 32'd1);
    chk("abort_start_busy", 32'(sif.busy), 32'd0);
    repeat (3) @(negedge clk);

    // Async reset mid-GAP (cycle 4 of the 0x05 x3 send)
    begin_xfer(8'h05, 4'd3, 4'd3, c);
    exp_bits(c, 1, 16'b101, 3);
    release_xfer();
    repeat (4) @(negedge clk);
    chk("gap_busy", 32'(sif.busy), 32'd1);
    chk("gap_y_valid", 32'(sif.y_valid), 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ready", 32'(sif.ready), 32'd1);
    chk("arst_busy", 32'(sif.busy), 32'd0);
    chk("arst_y_out", 32'(sif.y_out), 32'd0);
    chk("arst_y_valid", 32'(sif.y_valid), 32'd0);
    chk("arst_done", 32'(sif.done), 32'd0);
    chk("arst_sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    begin_xfer(8'h0F, 4'd4, 4'd1, c);
    exp_bits(c, 1, 16'b1111, 4);
    exp_done(c, 5);
    release_xfer();
    wait_done("t7_after_reset");

    repeat (3) @(negedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
